// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: single-outstanding data-memory responder.
//   A request is accepted in IDLE, its fields are latched, and after
//   LATENCY cycles a one-cycle response is issued. The word array is
//   accessed on the edge that enters RESP; loads return the word as it
//   was before that edge, stores echo the store data.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 32-bit words
//   LATENCY    - cycles from accept to response (1..15)
//
// Ports:
//   CLK        - clock, rising edge
//   RESET      - synchronous, active-low reset
//   req_valid  - request present
//   req_ready  - block can accept (IDLE only)
//   req_write  - 1 = store, 0 = load
//   req_addr   - byte address
//   req_wdata  - store data
//   resp_valid - one-cycle response strobe
//   resp_rdata - load data / echoed store data, 0 when resp_valid=0
//   resp_err   - error flag, qualified by resp_valid
//   busy       - request in flight (WAIT or RESP)
//
// Build option:
//   DMEM_ERR_EN - when defined, misaligned or out-of-range addresses do
//                 not touch the array and respond with resp_err=1,
//                 resp_rdata=0. When undefined, addr[1:0] is ignored and
//                 upper address bits alias.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [3:0]              cnt_nxt;
  logic                    accept;
  logic                    enter_resp;

  logic                    write_q;
  logic [31:0]             wdata_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    err_q;

  logic                    addr_err;
  logic                    acc_write;
  logic [31:0]             acc_wdata;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic                    acc_err;

  logic [31:0]             rdata_q;
  logic                    rerr_q;

  logic [31:0]             mem [WORDS];

  // The error decision depends only on the address, so it is evaluated on
  // the incoming address and latched together with the other fields.
`ifdef DMEM_ERR_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

  assign accept = (state == IDLE) && req_valid;

  // With LATENCY=1 the array is accessed on the accepting edge itself, so
  // the access uses the live request fields instead of the latched copies.
  always_comb begin
    acc_write = write_q;
    acc_wdata = wdata_q;
    acc_idx   = idx_q;
    acc_err   = err_q;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_wdata = req_wdata;
      acc_idx   = req_addr[DEPTH_LOG2+1:2];
      acc_err   = addr_err;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        if (acc_err) begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end else if (acc_write) begin
          rdata_q <= acc_wdata;
          rerr_q  <= 1'b0;
        end else begin
          rdata_q <= mem[acc_idx];
          rerr_q  <= 1'b0;
        end
      end
    end
  end

  // Request latches and the array carry no reset; the array write is gated
  // by RESET so a request aborted in WAIT never commits.
  always_ff @(posedge CLK) begin
    if (accept) begin
      write_q <= req_write;
      wdata_q <= req_wdata;
      idx_q   <= req_addr[DEPTH_LOG2+1:2];
      err_q   <= addr_err;
    end
    if (RESET && enter_resp && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & rerr_q;

endmodule
